lista_aberta_ordenada: RTL and testbench
========================================

LISTA_ABERTA_ORDENADA -- requirements
Module: lista_aberta_ordenada

Interface
REQ-001 SHALL have parameters NUM_NA, default 4, number of open-list slots; legal range NUM_NA >= 2.
REQ-002 SHALL have parameters ADDR_WIDTH (5), DISTANCIA_WIDTH (5), CUSTO_WIDTH (4, <= DISTANCIA_WIDTH) and CRITERIO_WIDTH (DISTANCIA_WIDTH+1).
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid_in  in  1  command request.
- cmd_op_in  in  2  command: 00 INSERIR, 01 RETIRAR, 10 LIMPAR, 11 no-op.
- endereco_in  in  ADDR_WIDTH  node address (INSERIR).
- anterior_in  in  ADDR_WIDTH  predecessor address (INSERIR).
- distancia_in  in  DISTANCIA_WIDTH  accumulated cost g (INSERIR).
- heuristica_in  in  CUSTO_WIDTH  heuristic h (INSERIR).
- cmd_ready_out  out  1  command accepted when cmd_valid_in & cmd_ready_out at a rising edge.
- res_valid_out  out  1  RETIRAR result valid.
- res_ready_in  in  1  result consumed.
- res_endereco_out, res_anterior_out  out  ADDR_WIDTH  popped entry.
- res_distancia_out  out  DISTANCIA_WIDTH  popped g.
- res_vazio_out  out  1  RETIRAR found the list empty.
- la_contagem_out  out  clog2(NUM_NA+1)  occupied slots.
- la_cheio_out, la_vazio_out  out  1  count == NUM_NA, count == 0.
- la_overflow_out  out  1  sticky: INSERIR dropped because the list was full.

Function
REQ-004 SHALL store per slot: valid bit, endereco, anterior, distancia and criterio = distancia_in + heuristica_in, computed in CRITERIO_WIDTH bits, saturating at all-ones.
REQ-005 SHALL implement the FSM OCIOSO -> INSERIR -> OCIOSO, OCIOSO -> VARRER -> RESULTADO -> OCIOSO; cmd_ready_out = 1 only in OCIOSO.
REQ-006 LIMPAR accepted at edge t SHALL clear all valid bits, the count and la_overflow_out at edge t; the FSM stays in OCIOSO.
REQ-007 A no-op accepted SHALL have no effect.
REQ-008 INSERIR accepted at edge t SHALL latch the inputs, occupy state INSERIR for one cycle, and commit at edge t+1; cmd_ready_out SHALL be high again from t+1.
REQ-009 INSERIR, when a valid slot holds the same endereco, SHALL overwrite that slot's anterior, distancia and criterio only if the new distancia is strictly smaller; otherwise no change, and the count is unchanged in both cases.
REQ-010 INSERIR of a new address SHALL write the lowest-index free slot and increment the count.
REQ-011 INSERIR of a new address into a full list SHALL drop the entry and set la_overflow_out at edge t+1.
REQ-012 RETIRAR accepted at edge t SHALL scan one slot per cycle, slot 0 first, during VARRER for NUM_NA cycles, with the best-so-far register replaced only on strictly smaller criterio, so the lowest index wins ties.
REQ-013 At edge t+NUM_NA+1 the FSM SHALL enter RESULTADO:
- res_valid_out = 1 with the winner's fields.
- Winner's valid bit cleared.
- Count decremented at the same edge.
REQ-014 RETIRAR on an empty list SHALL still take NUM_NA scan cycles, then present res_valid_out = 1, res_vazio_out = 1 and all-zero data fields.
REQ-015 Result outputs SHALL hold stable while res_valid_out = 1 and res_ready_in = 0; at the edge where both are 1, the FSM SHALL return to OCIOSO and res_valid_out SHALL drop.
REQ-016 la_cheio_out, la_vazio_out and la_contagem_out SHALL be registered-state derived and consistent with the slot valid bits every cycle.
REQ-017 cmd_op_in and data inputs SHALL be ignored when not accepted.

Reset
REQ-018 rst_n low SHALL asynchronously, including mid-scan or mid-result, force:
- FSM to OCIOSO, all slot valid bits 0.
- la_contagem_out = 0, la_vazio_out = 1, la_cheio_out = 0, la_overflow_out = 0.
- res_valid_out = 0, res_vazio_out = 0, res data fields 0.
- cmd_ready_out = 1 from the first edge after release.

Verification (NUM_NA=4, widths default)
REQ-019 INSERIR (addr 3, g 7, h 2), (addr 9, g 4, h 5), (addr 1, g 2, h 7); RETIRAR -> criterio 9 tie, so the result is addr 3 from slot 0, valid at accept+5, count 3 -> 2.
REQ-020 INSERIR (addr 5, g 10, h 1), then (addr 5, g 6, anterior 2), then (addr 5, g 8) -> count 1; RETIRAR returns g 6, anterior 2.
REQ-021 Five INSERIRs of distinct addresses -> la_cheio_out = 1 after the 4th, the 5th is dropped, la_overflow_out = 1; LIMPAR -> count 0, overflow 0.
REQ-022 RETIRAR on an empty list -> res_valid_out at accept+5 with res_vazio_out = 1, fields 0; hold res_ready_in = 0 for 3 cycles -> outputs stable, cmd_ready_out = 0.
REQ-023 Saturation with DISTANCIA_WIDTH=5: g 31, h 15 -> criterio 46, no wrap; with CRITERIO_WIDTH forced to 5 -> criterio 31.
REQ-024 Assert rst_n during VARRER after 3 entries -> outputs at reset values, a subsequent RETIRAR returns res_vazio_out = 1.

Source files
------------

// File: rtl/lista_aberta_ordenada.sv
// Ordered open list for A*: INSERIR keeps the best g per address, RETIRAR
// scans every slot and pops the entry with the smallest g+h (lowest slot wins ties).
module lista_aberta_ordenada #(
   parameter int NUM_NA          = 4,
   parameter int ADDR_WIDTH      = 5,
   parameter int DISTANCIA_WIDTH = 5,
   parameter int CUSTO_WIDTH     = 4,
   parameter int CRITERIO_WIDTH  = DISTANCIA_WIDTH + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid_in,
   input  logic [1:0]                   cmd_op_in,
   input  logic [ADDR_WIDTH-1:0]        endereco_in,
   input  logic [ADDR_WIDTH-1:0]        anterior_in,
   input  logic [DISTANCIA_WIDTH-1:0]   distancia_in,
   input  logic [CUSTO_WIDTH-1:0]       heuristica_in,
   output logic                         cmd_ready_out,
   output logic                         res_valid_out,
   input  logic                         res_ready_in,
   output logic [ADDR_WIDTH-1:0]        res_endereco_out,
   output logic [ADDR_WIDTH-1:0]        res_anterior_out,
   output logic [DISTANCIA_WIDTH-1:0]   res_distancia_out,
   output logic                         res_vazio_out,
   output logic [$clog2(NUM_NA+1)-1:0]  la_contagem_out,
   output logic                         la_cheio_out,
   output logic                         la_vazio_out,
   output logic                         la_overflow_out
);

   localparam int CNT_W = $clog2(NUM_NA + 1);
   localparam int IDX_W = $clog2(NUM_NA);
   localparam int SUM_W = (DISTANCIA_WIDTH + 1 > CRITERIO_WIDTH) ? DISTANCIA_WIDTH + 1 : CRITERIO_WIDTH;
   localparam logic [SUM_W-1:0] CRIT_MAX = SUM_W'((64'd1 << CRITERIO_WIDTH) - 64'd1);

   localparam logic [1:0] OP_INSERIR = 2'b00;
   localparam logic [1:0] OP_RETIRAR = 2'b01;
   localparam logic [1:0] OP_LIMPAR  = 2'b10;

   localparam logic [1:0] S_OCIOSO    = 2'd0;
   localparam logic [1:0] S_INSERIR   = 2'd1;
   localparam logic [1:0] S_VARRER    = 2'd2;
   localparam logic [1:0] S_RESULTADO = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic                        aceita;

   logic [NUM_NA-1:0]           valido_q;
   logic [ADDR_WIDTH-1:0]       end_mem_q  [NUM_NA];
   logic [ADDR_WIDTH-1:0]       ant_mem_q  [NUM_NA];
   logic [DISTANCIA_WIDTH-1:0]  dist_mem_q [NUM_NA];
   logic [CRITERIO_WIDTH-1:0]   crit_mem_q [NUM_NA];
   logic                        overflow_q;

   logic [ADDR_WIDTH-1:0]       ins_end_q, ins_ant_q;
   logic [DISTANCIA_WIDTH-1:0]  ins_dist_q;
   logic [CUSTO_WIDTH-1:0]      ins_heur_q;
   logic [SUM_W-1:0]            ins_soma;
   logic [CRITERIO_WIDTH-1:0]   ins_crit;

   logic                        hit, livre;
   logic [IDX_W-1:0]            hit_idx, livre_idx;
   logic [CNT_W-1:0]            contagem;

   logic [CNT_W-1:0]            scan_q;
   logic [IDX_W-1:0]            scan_idx;
   logic                        scan_fim, scan_melhor;
   logic                        best_ok_q;
   logic [IDX_W-1:0]            best_idx_q;
   logic [CRITERIO_WIDTH-1:0]   best_crit_q;

   logic [ADDR_WIDTH-1:0]       res_end_q, res_ant_q;
   logic [DISTANCIA_WIDTH-1:0]  res_dist_q;
   logic                        res_vazio_q;

   assign cmd_ready_out = (state_q == S_OCIOSO);
   assign aceita        = cmd_valid_in && cmd_ready_out;

   // Sum is formed wide enough never to wrap, then clamped to the criterio range.
   assign ins_soma = SUM_W'(ins_dist_q) + SUM_W'(ins_heur_q);
   assign ins_crit = (ins_soma > CRIT_MAX) ? '1 : CRITERIO_WIDTH'(ins_soma);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      hit       = 1'b0;
      hit_idx   = '0;
      livre     = 1'b0;
      livre_idx = '0;
      contagem  = '0;
      for (int i = NUM_NA - 1; i >= 0; i--) begin
         if (valido_q[i] && (end_mem_q[i] == ins_end_q)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valido_q[i]) begin
            livre     = 1'b1;
            livre_idx = IDX_W'(i);
         end
         contagem = contagem + CNT_W'(valido_q[i]);
      end
   end

   assign scan_idx    = IDX_W'(scan_q);
   assign scan_fim    = (scan_q == CNT_W'(NUM_NA));
   assign scan_melhor = !scan_fim && valido_q[scan_idx] &&
                        (!best_ok_q || (crit_mem_q[scan_idx] < best_crit_q));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_OCIOSO: begin
            if (aceita && cmd_op_in == OP_INSERIR) state_d = S_INSERIR;
            if (aceita && cmd_op_in == OP_RETIRAR) state_d = S_VARRER;
         end
         S_INSERIR:   state_d = S_OCIOSO;
         S_VARRER:    if (scan_fim) state_d = S_RESULTADO;
         S_RESULTADO: if (res_ready_in) state_d = S_OCIOSO;
         default:     state_d = S_OCIOSO;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_OCIOSO;
         valido_q    <= '0;
         overflow_q  <= 1'b0;
         scan_q      <= '0;
         best_ok_q   <= 1'b0;
         best_idx_q  <= '0;
         best_crit_q <= '0;
         res_end_q   <= '0;
         res_ant_q   <= '0;
         res_dist_q  <= '0;
         res_vazio_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_OCIOSO: begin
               if (aceita && cmd_op_in == OP_LIMPAR) begin
                  valido_q   <= '0;
                  overflow_q <= 1'b0;
               end
               if (aceita && cmd_op_in == OP_RETIRAR) begin
                  scan_q    <= '0;
                  best_ok_q <= 1'b0;
               end
            end
            S_INSERIR: begin
               if (!hit) begin
                  if (livre) valido_q[livre_idx] <= 1'b1;
                  else       overflow_q          <= 1'b1;
               end
            end
            S_VARRER: begin
               if (scan_fim) begin
                  res_vazio_q <= !best_ok_q;
                  res_end_q   <= best_ok_q ? end_mem_q[best_idx_q]  : '0;
                  res_ant_q   <= best_ok_q ? ant_mem_q[best_idx_q]  : '0;
                  res_dist_q  <= best_ok_q ? dist_mem_q[best_idx_q] : '0;
                  if (best_ok_q) valido_q[best_idx_q] <= 1'b0;
               end else begin
                  scan_q <= scan_q + CNT_W'(1);
                  if (scan_melhor) begin
                     best_ok_q   <= 1'b1;
                     best_idx_q  <= scan_idx;
                     best_crit_q <= crit_mem_q[scan_idx];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: slot payload and the latched command are not reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (aceita && cmd_op_in == OP_INSERIR) begin
         ins_end_q  <= endereco_in;
         ins_ant_q  <= anterior_in;
         ins_dist_q <= distancia_in;
         ins_heur_q <= heuristica_in;
      end
      if (state_q == S_INSERIR) begin
         if (hit) begin
            if (ins_dist_q < dist_mem_q[hit_idx]) begin
               ant_mem_q[hit_idx]  <= ins_ant_q;
               dist_mem_q[hit_idx] <= ins_dist_q;
               crit_mem_q[hit_idx] <= ins_crit;
            end
         end else if (livre) begin
            end_mem_q[livre_idx]  <= ins_end_q;
            ant_mem_q[livre_idx]  <= ins_ant_q;
            dist_mem_q[livre_idx] <= ins_dist_q;
            crit_mem_q[livre_idx] <= ins_crit;
         end
      end
   end

   assign res_valid_out     = (state_q == S_RESULTADO);
   assign res_endereco_out  = res_end_q;
   assign res_anterior_out  = res_ant_q;
   assign res_distancia_out = res_dist_q;
   assign res_vazio_out     = res_vazio_q;
   assign la_contagem_out   = contagem;
   assign la_cheio_out      = (contagem == CNT_W'(NUM_NA));
   assign la_vazio_out      = (contagem == '0);
   assign la_overflow_out   = overflow_q;

endmodule

// File: tb/tb_lista_aberta_ordenada.sv
// Bench for lista_aberta_ordenada: directed vector table, hand-written corner
// sequences, and random traffic against a slot-array reference model.
module tb_lista_aberta_ordenada;

   localparam int NUM_NA = 4;
   localparam int AW     = 5;
   localparam int DW     = 5;
   localparam int HW     = 4;
   localparam int CW     = DW + 1;

   localparam logic [1:0] OP_INS = 2'b00;
   localparam logic [1:0] OP_RET = 2'b01;
   localparam logic [1:0] OP_LIM = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid_in;
   logic [1:0]    cmd_op_in;
   logic [AW-1:0] endereco_in, anterior_in;
   logic [DW-1:0] distancia_in;
   logic [HW-1:0] heuristica_in;
   logic          res_ready_in;

   logic          cmd_ready_out, res_valid_out, res_vazio_out;
   logic [AW-1:0] res_endereco_out, res_anterior_out;
   logic [DW-1:0] res_distancia_out;
   logic [2:0]    la_contagem_out;
   logic          la_cheio_out, la_vazio_out, la_overflow_out;

   logic          s_ready, s_rv, s_rvz, s_cheio, s_vazio, s_ovf;
   logic [AW-1:0] s_re, s_ra;
   logic [DW-1:0] s_rd;
   logic [2:0]    s_cnt;

   always #5 clk = ~clk;

   lista_aberta_ordenada #(.NUM_NA(NUM_NA)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_in(cmd_valid_in), .cmd_op_in(cmd_op_in),
      .endereco_in(endereco_in), .anterior_in(anterior_in),
      .distancia_in(distancia_in), .heuristica_in(heuristica_in),
      .cmd_ready_out(cmd_ready_out), .res_valid_out(res_valid_out),
      .res_ready_in(res_ready_in), .res_endereco_out(res_endereco_out),
      .res_anterior_out(res_anterior_out), .res_distancia_out(res_distancia_out),
      .res_vazio_out(res_vazio_out), .la_contagem_out(la_contagem_out),
      .la_cheio_out(la_cheio_out), .la_vazio_out(la_vazio_out),
      .la_overflow_out(la_overflow_out)
   );

   // Same stimulus, criterio clamped to 5 bits.
   lista_aberta_ordenada #(.NUM_NA(NUM_NA), .CRITERIO_WIDTH(5)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_in(cmd_valid_in), .cmd_op_in(cmd_op_in),
      .endereco_in(endereco_in), .anterior_in(anterior_in),
      .distancia_in(distancia_in), .heuristica_in(heuristica_in),
      .cmd_ready_out(s_ready), .res_valid_out(s_rv),
      .res_ready_in(res_ready_in), .res_endereco_out(s_re),
      .res_anterior_out(s_ra), .res_distancia_out(s_rd),
      .res_vazio_out(s_rvz), .la_contagem_out(s_cnt),
      .la_cheio_out(s_cheio), .la_vazio_out(s_vazio),
      .la_overflow_out(s_ovf)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Reference model: plain slot arrays, policy stated directly.
   bit m_v    [NUM_NA];
   int m_end  [NUM_NA];
   int m_ant  [NUM_NA];
   int m_dist [NUM_NA];
   int m_crit [NUM_NA];
   bit m_ovf;

   function automatic int crit_of(input int g, input int h, input int width);
      int s;
      s = g + h;
      return (s > (1 << width) - 1) ? (1 << width) - 1 : s;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NUM_NA; i++) c += int'(m_v[i]);
      return c;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < NUM_NA; i++) m_v[i] = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic m_ins(input int a, input int p, input int g, input int h);
      for (int i = 0; i < NUM_NA; i++)
         if (m_v[i] && m_end[i] == a) begin
            if (g < m_dist[i]) begin
               m_ant[i] = p; m_dist[i] = g; m_crit[i] = crit_of(g, h, CW);
            end
            return;
         end
      for (int i = 0; i < NUM_NA; i++)
         if (!m_v[i]) begin
            m_v[i] = 1'b1; m_end[i] = a; m_ant[i] = p; m_dist[i] = g; m_crit[i] = crit_of(g, h, CW);
            return;
         end
      m_ovf = 1'b1;
   endtask

   task automatic m_ret(output bit vz, output int e, output int p, output int g);
      int best = -1;
      for (int i = 0; i < NUM_NA; i++)
         if (m_v[i] && (best < 0 || m_crit[i] < m_crit[best])) best = i;
      if (best < 0) begin
         vz = 1'b1; e = 0; p = 0; g = 0;
      end else begin
         vz = 1'b0; e = m_end[best]; p = m_ant[best]; g = m_dist[best];
         m_v[best] = 1'b0;
      end
   endtask

   logic [AW-1:0] sat_end, sat_ant;
   logic [DW-1:0] sat_dist;

   task automatic do_cmd(input logic [1:0] op, input int a, input int p, input int g, input int h);
      int n = 0;
      while (!cmd_ready_out && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) check("cmd_ready_timeout", cmd_ready_out, 1'b1);
      cmd_op_in     = op;
      endereco_in   = AW'(a);
      anterior_in   = AW'(p);
      distancia_in  = DW'(g);
      heuristica_in = HW'(h);
      cmd_valid_in  = 1'b1;
      @(posedge clk); #1;
      cmd_valid_in  = 1'b0;
      cmd_op_in     = 2'($urandom);
      endereco_in   = AW'($urandom);
      anterior_in   = AW'($urandom);
      distancia_in  = DW'($urandom);
      heuristica_in = HW'($urandom);
   endtask

   task automatic inserir(input int a, input int p, input int g, input int h);
      do_cmd(OP_INS, a, p, g, h);
      check("busy_in_inserir", cmd_ready_out, 1'b0);
      @(posedge clk); #1;
      check("ready_after_inserir", cmd_ready_out, 1'b1);
   endtask

   task automatic retirar(input bit consume, output logic vz, output logic [31:0] e,
                          output logic [31:0] p, output logic [31:0] g);
      int lat = 0;
      do_cmd(OP_RET, 0, 0, 0, 0);
      while (!res_valid_out && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("retirar_latency", lat, NUM_NA + 1);
      vz = res_vazio_out;
      e  = 32'(res_endereco_out);
      p  = 32'(res_anterior_out);
      g  = 32'(res_distancia_out);
      sat_end  = s_re;
      sat_ant  = s_ra;
      sat_dist = s_rd;
      if (consume) begin
         res_ready_in = 1'b1;
         @(posedge clk); #1;
         res_ready_in = 1'b0;
         check("res_valid_drop", res_valid_out, 1'b0);
      end
   endtask

   typedef struct {
      logic [1:0] op;
      int a, p, g, h;
      int cnt;
      bit ovf;
      bit vz;
      int re, rp, rg;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic [1:0] op, input int a, input int p, input int g, input int h,
                               input int cnt, input bit ovf, input bit vz,
                               input int re, input int rp, input int rg);
      vec_t v;
      v.op = op; v.a = a; v.p = p; v.g = g; v.h = h;
      v.cnt = cnt; v.ovf = ovf; v.vz = vz; v.re = re; v.rp = rp; v.rg = rg;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          vz;
      logic [31:0]   e, p, g;
      bit            mvz;
      int            me, mp, mg, r, a, pa, gd, hd;

      //               op      a  p   g  h  cnt ovf vz re rp rg
      vecs[0]  = mk(OP_INS,  3, 0,  7, 2, 1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(OP_INS,  9, 1,  4, 5, 2, 0, 0, 0, 0, 0);
      vecs[2]  = mk(OP_INS,  1, 2,  2, 7, 3, 0, 0, 0, 0, 0);
      vecs[3]  = mk(OP_RET,  0, 0,  0, 0, 2, 0, 0, 3, 0, 7);
      vecs[4]  = mk(OP_RET,  0, 0,  0, 0, 1, 0, 0, 9, 1, 4);
      vecs[5]  = mk(OP_RET,  0, 0,  0, 0, 0, 0, 0, 1, 2, 2);
      vecs[6]  = mk(OP_RET,  0, 0,  0, 0, 0, 0, 1, 0, 0, 0);
      vecs[7]  = mk(OP_INS,  5, 0, 10, 1, 1, 0, 0, 0, 0, 0);
      vecs[8]  = mk(OP_INS,  5, 2,  6, 1, 1, 0, 0, 0, 0, 0);
      vecs[9]  = mk(OP_INS,  5, 3,  8, 1, 1, 0, 0, 0, 0, 0);
      vecs[10] = mk(OP_RET,  0, 0,  0, 0, 0, 0, 0, 5, 2, 6);
      vecs[11] = mk(OP_INS, 10, 4,  1, 0, 1, 0, 0, 0, 0, 0);
      vecs[12] = mk(OP_INS, 11, 5,  2, 0, 2, 0, 0, 0, 0, 0);
      vecs[13] = mk(OP_INS, 12, 6,  3, 0, 3, 0, 0, 0, 0, 0);
      vecs[14] = mk(OP_INS, 13, 7,  4, 0, 4, 0, 0, 0, 0, 0);
      vecs[15] = mk(OP_NOP, 14, 8,  1, 0, 4, 0, 0, 0, 0, 0);
      vecs[16] = mk(OP_INS, 14, 8,  1, 0, 4, 1, 0, 0, 0, 0);

      cmd_valid_in = 1'b0; cmd_op_in = OP_NOP; endereco_in = '0; anterior_in = '0;
      distancia_in = '0; heuristica_in = '0; res_ready_in = 1'b0; rst_n = 1'b0;
      #2;
      check("rst_count", la_contagem_out, 0);
      check("rst_vazio", la_vazio_out, 1'b1);
      check("rst_cheio", la_cheio_out, 1'b0);
      check("rst_ovf", la_overflow_out, 1'b0);
      check("rst_res_valid", res_valid_out, 1'b0);
      check("rst_res_vazio", res_vazio_out, 1'b0);
      check("rst_res_end", res_endereco_out, 0);
      #20;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", cmd_ready_out, 1'b1);

      // Directed table
      for (int i = 0; i < 17; i++) begin
         case (vecs[i].op)
            OP_INS: inserir(vecs[i].a, vecs[i].p, vecs[i].g, vecs[i].h);
            OP_RET: begin
               retirar(1'b1, vz, e, p, g);
               check($sformatf("vec%0d_res_vazio", i), vz, vecs[i].vz);
               check($sformatf("vec%0d_res_end", i), e, vecs[i].re);
               check($sformatf("vec%0d_res_ant", i), p, vecs[i].rp);
               check($sformatf("vec%0d_res_dist", i), g, vecs[i].rg);
            end
            default: do_cmd(vecs[i].op, vecs[i].a, vecs[i].p, vecs[i].g, vecs[i].h);
         endcase
         check($sformatf("vec%0d_count", i), la_contagem_out, vecs[i].cnt);
         check($sformatf("vec%0d_ovf", i), la_overflow_out, vecs[i].ovf);
         check($sformatf("vec%0d_cheio", i), la_cheio_out, vecs[i].cnt == NUM_NA);
         check($sformatf("vec%0d_vazio", i), la_vazio_out, vecs[i].cnt == 0);
      end

      // LIMPAR clears count and overflow at the accepting edge
      do_cmd(OP_LIM, 0, 0, 0, 0);
      check("limpar_count", la_contagem_out, 0);
      check("limpar_ovf", la_overflow_out, 1'b0);
      check("limpar_ready", cmd_ready_out, 1'b1);

      // Empty RETIRAR, result held while res_ready_in is low; commands ignored meanwhile
      retirar(1'b0, vz, e, p, g);
      check("empty_vazio", vz, 1'b1);
      check("empty_end", e, 0);
      check("empty_ant", p, 0);
      check("empty_dist", g, 0);
      for (int k = 0; k < 3; k++) begin
         cmd_valid_in = 1'b1; cmd_op_in = OP_INS; endereco_in = AW'(k + 1);
         @(posedge clk); #1;
         check("hold_valid", res_valid_out, 1'b1);
         check("hold_vazio", res_vazio_out, 1'b1);
         check("hold_end", res_endereco_out, 0);
         check("hold_ready", cmd_ready_out, 1'b0);
      end
      cmd_valid_in = 1'b0;
      res_ready_in = 1'b1;
      @(posedge clk); #1;
      res_ready_in = 1'b0;
      check("hold_release", res_valid_out, 1'b0);
      check("hold_count", la_contagem_out, 0);

      // Saturation: 46 vs 45 in 6 bits, both clamp to 31 in 5 bits
      inserir(7, 1, 31, 15);
      inserir(8, 2, 30, 15);
      check("sat_count", s_cnt, 2);
      check("sat_ovf", s_ovf, 1'b0);
      retirar(1'b1, vz, e, p, g);
      check("sat6_first_end", e, 8);
      check("sat5_first_end", sat_end, 7);
      check("sat5_first_ant", sat_ant, 1);
      check("sat5_first_dist", sat_dist, 31);
      retirar(1'b1, vz, e, p, g);
      check("sat6_second_end", e, 7);
      check("sat6_second_dist", g, 31);
      check("sat5_second_end", sat_end, 8);
      check("sat5_vazio", s_vazio, 1'b1);
      check("sat5_ready", s_ready, 1'b1);
      check("sat5_cheio", s_cheio, 1'b0);
      check("sat5_rv", s_rv, 1'b0);
      check("sat5_rvz", s_rvz, 1'b0);

      // Reset during RESULTADO after holding a real entry
      inserir(6, 4, 3, 1);
      retirar(1'b0, vz, e, p, g);
      check("resq_end", e, 6);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check("resq_hold_end", res_endereco_out, 6);
         check("resq_hold_ant", res_anterior_out, 4);
         check("resq_hold_dist", res_distancia_out, 3);
      end
      #2 rst_n = 1'b0;
      #1;
      check("resq_rst_valid", res_valid_out, 1'b0);
      check("resq_rst_end", res_endereco_out, 0);
      check("resq_rst_ant", res_anterior_out, 0);
      check("resq_rst_dist", res_distancia_out, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a scan
      inserir(20, 1, 5, 1);
      inserir(21, 2, 6, 1);
      inserir(22, 3, 7, 1);
      inserir(23, 4, 8, 1);
      inserir(24, 5, 9, 1);
      check("scanrst_pre_ovf", la_overflow_out, 1'b1);
      do_cmd(OP_RET, 0, 0, 0, 0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("scanrst_count", la_contagem_out, 0);
      check("scanrst_vazio", la_vazio_out, 1'b1);
      check("scanrst_cheio", la_cheio_out, 1'b0);
      check("scanrst_ovf", la_overflow_out, 1'b0);
      check("scanrst_res_valid", res_valid_out, 1'b0);
      check("scanrst_res_vazio", res_vazio_out, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("scanrst_ready", cmd_ready_out, 1'b1);
      retirar(1'b1, vz, e, p, g);
      check("scanrst_after_vazio", vz, 1'b1);

      // Random traffic against the model
      m_clear();
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(99);
         if (r < 50) begin
            a  = $urandom_range(7);
            pa = $urandom_range(31);
            gd = $urandom_range(31);
            hd = $urandom_range(15);
            inserir(a, pa, gd, hd);
            m_ins(a, pa, gd, hd);
         end else if (r < 85) begin
            retirar(1'b1, vz, e, p, g);
            m_ret(mvz, me, mp, mg);
            check("rnd_res_vazio", vz, mvz);
            check("rnd_res_end", e, me);
            check("rnd_res_ant", p, mp);
            check("rnd_res_dist", g, mg);
         end else if (r < 90) begin
            do_cmd(OP_LIM, 0, 0, 0, 0);
            m_clear();
         end else begin
            do_cmd(OP_NOP, $urandom_range(7), 0, 0, 0);
         end
         check("rnd_count", la_contagem_out, m_count());
         check("rnd_ovf", la_overflow_out, m_ovf);
         check("rnd_cheio", la_cheio_out, m_count() == NUM_NA);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
